conjugate_complex_vector_chunk_feeder: RTL and testbench
========================================================

# conjugate_complex_vector_chunk_feeder

Upstream feeder for the conjugate complex vector-by-vector dot-product stage. Given two base addresses and an element count, it streams both operand vectors out of two chunk-wide synchronous RAMs, one chunk of `no_of_units` complex elements per transfer. It zero-pads the tail chunk and presents each chunk pair on `first_row_plus_additional`/`vector2` with a one-cycle `outsider_read_now` strobe, paced by the consumer's `I_am_ready`.

## Interface
- `element_width`, 64, bits per complex element: [63:32] real, [31:0] imag, two's complement.
- `no_of_units`, 8, elements per chunk (lanes); lane k occupies bits [element_width*(k+1)-1 : element_width*k].
- `addr_width`, 16, RAM chunk-address width.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a pass; sampled only in IDLE.
- `total` in 32: element count; latched on accepted `start`.
- `base_a` in addr_width: chunk base of operand A; latched on `start`.
- `base_b` in addr_width: chunk base of operand B; latched on `start`.
- `mem_a_rd_en`, `mem_b_rd_en` out 1: RAM read enables.
- `mem_a_addr`, `mem_b_addr` out addr_width: RAM chunk addresses.
- `mem_a_rdata`, `mem_b_rdata` in element_width*no_of_units: RAM data, valid the cycle after `rd_en`.
- `I_am_ready` in 1: consumer may accept a chunk.
- `first_row_plus_additional` out element_width*no_of_units: operand A chunk.
- `vector2` out element_width*no_of_units: operand B chunk.
- `outsider_read_now` out 1: chunk-valid strobe.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse after the last chunk.

## Operation
- States: IDLE, READ, LOAD, PRESENT, GAP, FINISH.
- IDLE:
  - `start`=1 and `total`≠0 → READ. Latch `total`, `base_a`, `base_b`; chunk index `idx`=0.
  - `start`=1 and `total`=0 → FINISH, no RAM access.
- READ: `mem_*_rd_en`=1, `mem_*_addr` = base + idx (mod 2^addr_width) → LOAD.
- LOAD: register the masked `mem_*_rdata` into the output buses → PRESENT.
- PRESENT:
  - If `I_am_ready`=1: `outsider_read_now`=1 for this cycle; then → GAP if more chunks remain, otherwise → FINISH.
  - Otherwise hold and wait; the strobe stays low.
- GAP: one idle cycle (the consumer needs 2 cycles per capture); idx += 1 → READ.
- FINISH: `done`=1 → IDLE.
- Chunk count N = ceil(total / no_of_units), computed with a 32-bit add-then-shift. No overflow for total ≤ 2^32−no_of_units.
- Tail mask: remaining r = total − idx·no_of_units. Lane k is forced to 0 on both operands when k ≥ r; full chunks pass unmasked.
- Output buses change only at the end of LOAD and hold until the next LOAD. Stale data stays visible after `done` until reset or the next pass.
- `start` is ignored when not in IDLE. `busy` = (state ≠ IDLE).
- Reset at any point: state IDLE, idx 0, no `done` pulse. An aborted chunk is never strobed.

## Timing
- Reset values: all outputs 0, including both data buses, addresses, `rd_en`, `outsider_read_now`, `busy` and `done`.
- `start` sampled at edge E0: READ during cycle E0+1, LOAD E0+2, first `outsider_read_now` in cycle E0+3 (if `I_am_ready`=1).
- Chunk period is 4 cycles with `I_am_ready` held high.
- `done` goes high in the cycle after the last strobe. A total=0 pass pulses `done` in cycle E0+1.
- `outsider_read_now` is never high on two consecutive cycles and is never high while `I_am_ready`=0.
- RAM read latency is exactly 1 cycle; no other latency is supported.

## Structure
- Shared package holds:
  - default `element_width` and `no_of_units`;
  - the state encoding (6 states, 3 bits);
  - the real/imag field offsets, shared with the dot-product stage.
- One sub-module, `complex_chunk_tail_mask`: purely combinational. It takes a chunk plus a remaining count and zeroes lanes ≥ count. It is instantiated twice (A and B).
- The FSM, idx counter and address adders live in the top module.

## Test plan
- total=16, base_a=0x0010, base_b=0x0200, ready high → reads at 0x0010/0x0200, then 0x0011/0x0201. Two strobes 4 cycles apart, `done` in the following cycle, data equals RAM words.
- total=13 → 2 chunks. On the second chunk lanes 0–4 pass through and lanes 5–7 are 0 on both buses.
- total=0, `start` pulse → `done` high the next cycle, no `rd_en`, no strobe, `busy` high for one cycle.
- `I_am_ready` low for 5 cycles while in PRESENT → strobe withheld and buses stable. Strobe fires in the cycle `I_am_ready` returns high.
- base_a=0xFFFF, total=16 → second read at address 0x0000.
- Reset asserted during LOAD of chunk 1 of 3 → all outputs 0 next cycle, no `done`. A fresh `start` restarts from idx 0.

Source files
------------

// File: rtl/conjugate_complex_vector_chunk_feeder_pkg.sv
// Shared constants for the conjugate complex dot-product feeder: default geometry,
// FSM state encoding and the real/imag field layout of one complex element.
package conjugate_complex_vector_chunk_feeder_pkg;

    localparam int ELEMENT_WIDTH = 64;
    localparam int NO_OF_UNITS   = 8;

    // Field layout of one element; the dot-product stage uses the same offsets.
    localparam int PART_WIDTH = ELEMENT_WIDTH / 2;
    localparam int REAL_LSB   = PART_WIDTH;
    localparam int IMAG_LSB   = 0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;

endpackage

// File: rtl/conjugate_complex_vector_chunk_feeder_tail_mask.sv
// Combinational tail mask: lanes at or above the remaining element count read as zero.
module complex_chunk_tail_mask
    import conjugate_complex_vector_chunk_feeder_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int no_of_units   = NO_OF_UNITS
) (
    input  logic [element_width*no_of_units-1:0] chunk_in,
    input  logic [31:0]                          remaining,
    output logic [element_width*no_of_units-1:0] chunk_out
);

    generate
        for (genvar gi = 0; gi < no_of_units; gi++) begin : g_lane
            assign chunk_out[gi*element_width +: element_width] =
                (32'(gi) < remaining) ? chunk_in[gi*element_width +: element_width]
                                      : '0;
        end
    endgenerate

endmodule

// File: rtl/conjugate_complex_vector_chunk_feeder.sv
// Streams two complex operand vectors out of chunk-wide RAMs, zero-pads the tail
// chunk and hands each chunk pair to the dot-product stage under I_am_ready pacing.
module conjugate_complex_vector_chunk_feeder
    import conjugate_complex_vector_chunk_feeder_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int no_of_units   = NO_OF_UNITS,
    parameter int addr_width    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    input  logic [addr_width-1:0]                base_a,
    input  logic [addr_width-1:0]                base_b,
    output logic                                 mem_a_rd_en,
    output logic                                 mem_b_rd_en,
    output logic [addr_width-1:0]                mem_a_addr,
    output logic [addr_width-1:0]                mem_b_addr,
    input  logic [element_width*no_of_units-1:0] mem_a_rdata,
    input  logic [element_width*no_of_units-1:0] mem_b_rdata,
    input  logic                                 I_am_ready,
    output logic [element_width*no_of_units-1:0] first_row_plus_additional,
    output logic [element_width*no_of_units-1:0] vector2,
    output logic                                 outsider_read_now,
    output logic                                 busy,
    output logic                                 done
);

    localparam int bus_width  = element_width * no_of_units;
    // no_of_units is a power of two, so chunk arithmetic reduces to shifts.
    localparam int lane_shift = $clog2(no_of_units);

    logic [2:0]            state_reg, state_next;
    logic [31:0]           idx_reg;
    logic [31:0]           total_reg;
    logic [31:0]           chunks_reg;
    logic [addr_width-1:0] base_a_reg, base_b_reg;
    logic [bus_width-1:0]  a_bus_reg, b_bus_reg;

    logic [31:0]           chunk_count;
    logic [31:0]           remaining;
    logic                  last_chunk;
    logic [bus_width-1:0]  a_masked, b_masked;

    assign chunk_count = (total + 32'(no_of_units - 1)) >> lane_shift;
    assign remaining   = total_reg - (idx_reg << lane_shift);
    assign last_chunk  = (idx_reg == chunks_reg - 32'd1);

    complex_chunk_tail_mask #(
        .element_width(element_width),
        .no_of_units  (no_of_units)
    ) u_mask_a (
        .chunk_in (mem_a_rdata),
        .remaining(remaining),
        .chunk_out(a_masked)
    );

    complex_chunk_tail_mask #(
        .element_width(element_width),
        .no_of_units  (no_of_units)
    ) u_mask_b (
        .chunk_in (mem_b_rdata),
        .remaining(remaining),
        .chunk_out(b_masked)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = (total != 32'd0) ? ST_READ : ST_FINISH;
            ST_READ:    state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_PRESENT;
            ST_PRESENT: if (I_am_ready) state_next = last_chunk ? ST_FINISH : ST_GAP;
            ST_GAP:     state_next = ST_READ;
            ST_FINISH:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            total_reg  <= '0;
            chunks_reg <= '0;
            base_a_reg <= '0;
            base_b_reg <= '0;
            a_bus_reg  <= '0;
            b_bus_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start && total != 32'd0) begin
                total_reg  <= total;
                chunks_reg <= chunk_count;
                base_a_reg <= base_a;
                base_b_reg <= base_b;
                idx_reg    <= '0;
            end
            if (state_reg == ST_GAP)
                idx_reg <= idx_reg + 32'd1;
            if (state_reg == ST_LOAD) begin
                a_bus_reg <= a_masked;
                b_bus_reg <= b_masked;
            end
        end
    end

    // Addresses wrap modulo 2^addr_width; they idle at zero outside READ.
    assign mem_a_rd_en = (state_reg == ST_READ);
    assign mem_b_rd_en = (state_reg == ST_READ);
    assign mem_a_addr  = mem_a_rd_en ? base_a_reg + idx_reg[addr_width-1:0] : '0;
    assign mem_b_addr  = mem_b_rd_en ? base_b_reg + idx_reg[addr_width-1:0] : '0;

    assign first_row_plus_additional = a_bus_reg;
    assign vector2                   = b_bus_reg;
    assign outsider_read_now         = (state_reg == ST_PRESENT) && I_am_ready;
    assign busy                      = (state_reg != ST_IDLE);
    assign done                      = (state_reg == ST_FINISH);

endmodule

// File: tb/tb_conjugate_complex_vector_chunk_feeder.sv
// Directed bench for the chunk feeder with two behavioural 1-cycle-latency RAMs.
module tb_conjugate_complex_vector_chunk_feeder;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int AW = 16;
    localparam int BW = EW * NU;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   total;
    logic [AW-1:0] base_a, base_b;
    logic          mem_a_rd_en, mem_b_rd_en;
    logic [AW-1:0] mem_a_addr, mem_b_addr;
    logic [BW-1:0] mem_a_rdata, mem_b_rdata;
    logic          I_am_ready;
    logic [BW-1:0] first_row_plus_additional, vector2;
    logic          outsider_read_now, busy, done;

    int n_checks = 0;
    int n_fails  = 0;

    conjugate_complex_vector_chunk_feeder dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .total                    (total),
        .base_a                   (base_a),
        .base_b                   (base_b),
        .mem_a_rd_en              (mem_a_rd_en),
        .mem_b_rd_en              (mem_b_rd_en),
        .mem_a_addr               (mem_a_addr),
        .mem_b_addr               (mem_b_addr),
        .mem_a_rdata              (mem_a_rdata),
        .mem_b_rdata              (mem_b_rdata),
        .I_am_ready               (I_am_ready),
        .first_row_plus_additional(first_row_plus_additional),
        .vector2                  (vector2),
        .outsider_read_now        (outsider_read_now),
        .busy                     (busy),
        .done                     (done)
    );

    always #5 clk = ~clk;

    // RAM word content is a function of bank, address and lane.
    function automatic logic [BW-1:0] ram_word(input logic [7:0] bank, input logic [AW-1:0] addr);
        logic [BW-1:0] w;
        for (int k = 0; k < NU; k++)
            w[k*EW +: EW] = {bank, 8'(k), addr, addr, 8'(k), ~bank};
        return w;
    endfunction

    function automatic logic [BW-1:0] expect_chunk(input logic [7:0] bank, input logic [AW-1:0] addr,
                                                   input int unsigned tot, input int unsigned idx);
        logic [BW-1:0] w;
        longint rem;
        w   = ram_word(bank, addr);
        rem = longint'(tot) - longint'(idx) * NU;
        for (int k = 0; k < NU; k++)
            if (k >= rem) w[k*EW +: EW] = '0;
        return w;
    endfunction

    // Garbage whenever no read was issued, so a wrong read latency shows up in the data.
    always @(posedge clk) begin
        mem_a_rdata <= mem_a_rd_en ? ram_word(8'hA5, mem_a_addr) : {16{32'hDEADBEEF}};
        mem_b_rdata <= mem_b_rd_en ? ram_word(8'h5B, mem_b_addr) : {16{32'hBADC0FFE}};
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".rd_en"}, BW'({mem_a_rd_en, mem_b_rd_en}), '0);
        check({tag, ".addr"}, BW'({mem_a_addr, mem_b_addr}), '0);
        check({tag, ".flags"}, BW'({outsider_read_now, busy, done}), '0);
        check({tag, ".bus_a"}, first_row_plus_additional, '0);
        check({tag, ".bus_b"}, vector2, '0);
    endtask

    // Full pass with I_am_ready high; called at a falling edge.
    task automatic do_pass(input int unsigned tot, input logic [AW-1:0] ba, input logic [AW-1:0] bb);
        int unsigned n;
        logic [AW-1:0] aa, ab;
        n = (tot + NU - 1) / NU;
        start = 1'b1; total = tot; base_a = ba; base_b = bb;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            aa = ba + AW'(i);
            ab = bb + AW'(i);
            $display("pass total=%0d chunk %0d addr_a=%h addr_b=%h", tot, i, aa, ab);
            check("read.rd_en", BW'({mem_a_rd_en, mem_b_rd_en, busy}), BW'(3'b111));
            check("read.addr_a", BW'(mem_a_addr), BW'(aa));
            check("read.addr_b", BW'(mem_b_addr), BW'(ab));
            @(negedge clk);
            check("load.strobe", BW'({outsider_read_now, mem_a_rd_en}), '0);
            @(negedge clk);
            check("present.strobe", BW'(outsider_read_now), BW'(1'b1));
            check("present.bus_a", first_row_plus_additional, expect_chunk(8'hA5, aa, tot, i));
            check("present.bus_b", vector2, expect_chunk(8'h5B, ab, tot, i));
            @(negedge clk);
            if (i + 1 < n) begin
                check("gap.strobe_done", BW'({outsider_read_now, done}), '0);
                @(negedge clk);
            end
        end
        check("finish.done", BW'({done, busy, outsider_read_now}), BW'(3'b110));
        @(negedge clk);
        check("after.done", BW'({done, busy}), '0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; total = '0; base_a = '0; base_b = '0; I_am_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        do_pass(16, 16'h0010, 16'h0200);
        do_pass(13, 16'h0040, 16'h0080);

        // Zero-length pass: done one cycle later, no RAM traffic.
        start = 1'b1; total = 0;
        @(negedge clk);
        start = 1'b0;
        $display("pass total=0");
        check("zero.done_busy", BW'({done, busy}), BW'(2'b11));
        check("zero.rd_strobe", BW'({mem_a_rd_en, mem_b_rd_en, outsider_read_now}), '0);
        @(negedge clk);
        check("zero.after", BW'({done, busy}), '0);

        // Back-pressure: consumer not ready for 5 cycles in PRESENT.
        I_am_ready = 1'b0;
        start = 1'b1; total = 8; base_a = 16'h0300; base_b = 16'h0400;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            $display("stall cycle %0d", c);
            check("stall.strobe", BW'({outsider_read_now, busy}), BW'(2'b01));
            check("stall.bus_a", first_row_plus_additional, expect_chunk(8'hA5, 16'h0300, 8, 0));
            check("stall.bus_b", vector2, expect_chunk(8'h5B, 16'h0400, 8, 0));
            @(negedge clk);
        end
        I_am_ready = 1'b1;
        #1;
        check("stall.release_strobe", BW'(outsider_read_now), BW'(1'b1));
        @(negedge clk);
        check("stall.done", BW'({done, outsider_read_now}), BW'(2'b10));
        @(negedge clk);

        // Address wrap on operand A.
        do_pass(16, 16'hFFFF, 16'h1234);

        // Reset during LOAD of chunk 1 of a 3-chunk pass.
        start = 1'b1; total = 24; base_a = 16'h0100; base_b = 16'h0500;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort.read1_addr", BW'({mem_a_rd_en, mem_a_addr}), BW'({1'b1, 16'h0101}));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        $display("reset during load");
        check_idle_outputs("abort");
        reset = 1'b0;
        @(negedge clk);
        check("abort.no_done", BW'({done, busy, outsider_read_now}), '0);
        do_pass(8, 16'h0100, 16'h0500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
